mem_arbiter_rr: RTL and testbench

- Parametrised N-master arbiter between the cache/uncache clients (icache, dcache, uncache, ...) and the single AXI-like memory port.
- Independent read and write paths, each with its own FSM and round-robin pointer.
- One outstanding transaction per path; multi-beat reads are routed to the owner by a registered grant.
- Replaces fixed-priority combinational selection with registered grants, ready/valid handshakes and fair scheduling.

---
 rtl/mem_arbiter_rr_pkg.sv | 28 ++
 rtl/mem_arbiter_rr_pick.sv | 32 +++
 rtl/mem_arbiter_rr.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types and constants for the round-robin memory arbiter.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package mem_arbiter_rr_pkg;

  // Default bus geometry
  localparam int DEF_AW  = 32;
  localparam int DEF_DW  = 64;
  localparam int DEF_IDW = 4;

  // Fixed master slots
  localparam int MST_ICACHE  = 0;
  localparam int MST_DCACHE  = 1;
  localparam int MST_UNCACHE = 2;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_SEND = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the pick.
module mem_arbiter_rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          any_req
);

  // Scan from ptr upward; the first hit wins, later hits are masked by any_req
  always_comb begin
    logic [IW-1:0] j;
    gnt_oh  = '0;
    gnt_idx = '0;
    any_req = 1'b0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!any_req && req[j]) begin
        any_req    = 1'b1;
        gnt_idx    = j;
        gnt_oh[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-master arbiter onto one AXI-like port; independent read/write FSMs with round-robin pointers.
// Latency: 1 cycle request->ar/aw_valid; 1 cycle r beat->m_rvalid; 1 cycle b->m_wdone.
// Backpressure: one outstanding txn per path; ar/aw/w valids hold until ready; requests wait while busy.
module mem_arbiter_rr
  import mem_arbiter_rr_pkg::*;
#(
  parameter int N_MST = 3,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int IDW   = DEF_IDW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_MST-1:0]        m_rreq,
  input  logic [N_MST*AW-1:0]     m_raddr,
  output logic [DW-1:0]           m_rdata,
  output logic [N_MST-1:0]        m_rvalid,
  output logic [N_MST-1:0]        m_rdone,
  input  logic [N_MST-1:0]        m_wreq,
  input  logic [N_MST*AW-1:0]     m_waddr,
  input  logic [N_MST*DW-1:0]     m_wdata,
  input  logic [N_MST*DW/8-1:0]   m_wstrb,
  output logic [N_MST-1:0]        m_wdone,
  output logic                    ar_valid,
  input  logic                    ar_ready,
  output logic [IDW-1:0]          ar_id,
  output logic [AW-1:0]           ar_addr,
  input  logic                    r_valid,
  input  logic [IDW-1:0]          r_id,
  input  logic [DW-1:0]           r_data,
  input  logic                    r_last,
  output logic                    aw_valid,
  input  logic                    aw_ready,
  output logic [IDW-1:0]          aw_id,
  output logic [AW-1:0]           aw_addr,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [DW-1:0]           w_data,
  output logic [DW/8-1:0]         w_strb,
  input  logic                    b_valid,
  input  logic [IDW-1:0]          b_id,
  output logic                    stall_o
);

  localparam int IW = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int SW = DW / 8;

  rd_state_e        rd_state;
  wr_state_e        wr_state;
  logic [IW-1:0]    rd_ptr, wr_ptr;
  logic [IW-1:0]    rgnt, wgnt;
  logic [N_MST-1:0] rgnt_oh, wgnt_oh;
  logic [N_MST-1:0] r_oh, w_oh;
  logic [IW-1:0]    r_idx, w_idx;
  logic             r_any, w_any;
  logic             aw_done, w_done;
  logic             aw_hs, w_hs;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] cur);
    return (cur == IW'(N_MST - 1)) ? '0 : cur + 1'b1;
  endfunction

  mem_arbiter_rr_pick #(.N(N_MST), .IW(IW)) u_rd_pick (
    .req     (m_rreq),
    .ptr     (rd_ptr),
    .gnt_oh  (r_oh),
    .gnt_idx (r_idx),
    .any_req (r_any)
  );

  mem_arbiter_rr_pick #(.N(N_MST), .IW(IW)) u_wr_pick (
    .req     (m_wreq),
    .ptr     (wr_ptr),
    .gnt_oh  (w_oh),
    .gnt_idx (w_idx),
    .any_req (w_any)
  );

  assign aw_hs = aw_valid & aw_ready;
  assign w_hs  = w_valid & w_ready;

  // Stall while anyone is asking or either path is busy; forced low in reset
  assign stall_o = rst & ((|m_rreq) | (|m_wreq) | (rd_state != R_IDLE) | (wr_state != W_IDLE));

  // Read path: grant, address phase, then route matching beats to the owner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= R_IDLE;
      rd_ptr   <= '0;
      rgnt     <= '0;
      rgnt_oh  <= '0;
      ar_valid <= 1'b0;
      ar_id    <= '0;
      ar_addr  <= '0;
      m_rdata  <= '0;
      m_rvalid <= '0;
      m_rdone  <= '0;
    end else begin
      m_rvalid <= '0;
      m_rdone  <= '0;
      case (rd_state)
        R_IDLE: if (r_any) begin
          rgnt     <= r_idx;
          rgnt_oh  <= r_oh;
          ar_id    <= IDW'(r_idx);
          ar_addr  <= m_raddr[r_idx*AW +: AW];
          ar_valid <= 1'b1;
          rd_state <= R_ADDR;
        end
        R_ADDR: if (ar_ready) begin
          ar_valid <= 1'b0;
          rd_ptr   <= next_ptr(rgnt);
          rd_state <= R_DATA;
        end
        R_DATA: if (r_valid && (r_id == IDW'(rgnt))) begin
          // A master that abandoned its request gets nothing back
          if (|(m_rreq & rgnt_oh)) begin
            m_rdata  <= r_data;
            m_rvalid <= rgnt_oh;
            if (r_last) m_rdone <= rgnt_oh;
          end
          if (r_last) rd_state <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Write path: grant, AW and W complete independently, then wait for matching B
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state <= W_IDLE;
      wr_ptr   <= '0;
      wgnt     <= '0;
      wgnt_oh  <= '0;
      aw_valid <= 1'b0;
      aw_id    <= '0;
      aw_addr  <= '0;
      w_valid  <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      m_wdone  <= '0;
    end else begin
      m_wdone <= '0;
      case (wr_state)
        W_IDLE: if (w_any) begin
          wgnt     <= w_idx;
          wgnt_oh  <= w_oh;
          aw_id    <= IDW'(w_idx);
          aw_addr  <= m_waddr[w_idx*AW +: AW];
          w_data   <= m_wdata[w_idx*DW +: DW];
          w_strb   <= m_wstrb[w_idx*SW +: SW];
          aw_valid <= 1'b1;
          w_valid  <= 1'b1;
          aw_done  <= 1'b0;
          w_done   <= 1'b0;
          wr_state <= W_SEND;
        end
        W_SEND: begin
          if (aw_hs) begin
            aw_valid <= 1'b0;
            aw_done  <= 1'b1;
          end
          if (w_hs) begin
            w_valid <= 1'b0;
            w_done  <= 1'b1;
          end
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            wr_ptr   <= next_ptr(wgnt);
            wr_state <= W_RESP;
          end
        end
        W_RESP: if (b_valid && (b_id == IDW'(wgnt))) begin
          if (|(m_wreq & wgnt_oh)) m_wdone <= wgnt_oh;
          wr_state <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr with hand-computed expectations.
module tb_mem_arbiter_rr;
  localparam int N = 3, AW = 32, DW = 64, IDW = 4, SW = DW / 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     m_rreq, m_rvalid, m_rdone, m_wreq, m_wdone;
  logic [N*AW-1:0]  m_raddr, m_waddr;
  logic [DW-1:0]    m_rdata;
  logic [N*DW-1:0]  m_wdata;
  logic [N*SW-1:0]  m_wstrb;
  logic             ar_valid, ar_ready, r_valid, r_last;
  logic             aw_valid, aw_ready, w_valid, w_ready, b_valid, stall_o;
  logic [IDW-1:0]   ar_id, r_id, aw_id, b_id;
  logic [AW-1:0]    ar_addr, aw_addr;
  logic [DW-1:0]    r_data, w_data;
  logic [SW-1:0]    w_strb;

  int checks = 0;
  int errors = 0;
  int exp_ord[4] = '{0, 1, 2, 0};

  mem_arbiter_rr #(.N_MST(N), .AW(AW), .DW(DW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .m_rreq(m_rreq), .m_raddr(m_raddr), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rdone(m_rdone),
    .m_wreq(m_wreq), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wdone(m_wdone),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_id(r_id), .r_data(r_data), .r_last(r_last),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_id(b_id), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    m_rreq = '0; m_raddr = '0; m_wreq = '0; m_waddr = '0; m_wdata = '0; m_wstrb = '0;
    ar_ready = 0; r_valid = 0; r_id = '0; r_data = '0; r_last = 0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_id = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_ar(input string tag);
    int n = 0;
    while (ar_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check(tag, 64'(ar_valid), 64'd1);
  endtask

  initial begin
    do_reset();

    // Reset state
    check("rst_ar_valid", 64'(ar_valid), 0);
    check("rst_aw_valid", 64'(aw_valid), 0);
    check("rst_w_valid", 64'(w_valid), 0);
    check("rst_stall", 64'(stall_o), 0);
    check("rst_rvalid", 64'(m_rvalid), 0);
    check("rst_wdone", 64'(m_wdone), 0);
    check("rst_ar_addr", 64'(ar_addr), 0);

    // Single 4-beat read for icache
    m_rreq = 3'b001;
    m_raddr[0*AW +: AW] = 32'h8000_0000;
    #1;
    check("single_stall_req", 64'(stall_o), 1);
    tick();
    check("single_ar_valid", 64'(ar_valid), 1);
    check("single_ar_id", 64'(ar_id), 0);
    check("single_ar_addr", 64'(ar_addr), 64'h8000_0000);
    tick();
    tick();
    check("single_ar_hold", 64'(ar_addr), 64'h8000_0000);
    ar_ready = 1;
    tick();
    ar_ready = 0;
    check("single_ar_drop", 64'(ar_valid), 0);
    for (int b = 1; b <= 4; b++) begin
      r_valid = 1; r_id = 0; r_data = 64'h1000 + 64'(b); r_last = (b == 4);
      tick();
      check("single_rvalid", 64'(m_rvalid), 64'b001);
      check("single_rdata", m_rdata, 64'h1000 + 64'(b));
      check("single_rdone", 64'(m_rdone), (b == 4) ? 64'b001 : 64'b000);
    end
    r_valid = 0; r_last = 0; m_rreq = '0;
    tick();
    check("single_stall_end", 64'(stall_o), 0);
    check("single_rvalid_end", 64'(m_rvalid), 0);

    // Fairness: all three hold requests, single-beat reads
    do_reset();
    m_rreq = 3'b111;
    for (int i = 0; i < N; i++) m_raddr[i*AW +: AW] = 32'(32'h100 * (i + 1));
    for (int g = 0; g < 4; g++) begin
      wait_ar("fair_ar_valid");
      check("fair_ar_id", 64'(ar_id), 64'(exp_ord[g]));
      check("fair_ar_addr", 64'(ar_addr), 64'(32'h100 * (exp_ord[g] + 1)));
      ar_ready = 1;
      tick();
      ar_ready = 0;
      r_valid = 1; r_id = IDW'(exp_ord[g]); r_data = 64'(g); r_last = 1;
      tick();
      r_valid = 0; r_last = 0;
      check("fair_rdone", 64'(m_rdone), 64'(1) << exp_ord[g]);
    end
    m_rreq = '0;
    tick();

    // Concurrent read (icache) and write (dcache)
    m_rreq = 3'b001; m_raddr[0*AW +: AW] = 32'h0000_A000;
    m_wreq = 3'b010; m_waddr[1*AW +: AW] = 32'h0000_B000;
    m_wdata[1*DW +: DW] = 64'hDEAD_BEEF_0000_1111; m_wstrb[1*SW +: SW] = 8'h0F;
    tick();
    check("conc_ar_valid", 64'(ar_valid), 1);
    check("conc_aw_valid", 64'(aw_valid), 1);
    check("conc_w_valid", 64'(w_valid), 1);
    check("conc_aw_id", 64'(aw_id), 1);
    check("conc_aw_addr", 64'(aw_addr), 64'h0000_B000);
    check("conc_w_strb", 64'(w_strb), 64'h0F);
    check("conc_w_data", w_data, 64'hDEAD_BEEF_0000_1111);
    ar_ready = 1; aw_ready = 1; w_ready = 1;
    tick();
    ar_ready = 0; aw_ready = 0; w_ready = 0;
    check("conc_aw_drop", 64'(aw_valid), 0);
    r_valid = 1; r_id = 0; r_data = 64'h55AA; r_last = 1;
    b_valid = 1; b_id = 1;
    tick();
    r_valid = 0; r_last = 0; b_valid = 0;
    check("conc_rdone", 64'(m_rdone), 64'b001);
    check("conc_wdone", 64'(m_wdone), 64'b010);
    m_rreq = '0; m_wreq = '0;
    tick();
    check("conc_wdone_pulse", 64'(m_wdone), 0);

    // Split AW/W handshakes for an icache write
    m_wreq = 3'b001; m_waddr[0*AW +: AW] = 32'h0000_C000;
    m_wdata[0*DW +: DW] = 64'h0123_4567_89AB_CDEF; m_wstrb[0*SW +: SW] = 8'hFF;
    tick();
    check("split_aw_addr", 64'(aw_addr), 64'h0000_C000);
    check("split_w_strb", 64'(w_strb), 64'hFF);
    aw_ready = 1;
    tick();
    aw_ready = 0;
    check("split_aw_drop", 64'(aw_valid), 0);
    check("split_w_hold", 64'(w_valid), 1);
    b_valid = 1; b_id = 0;
    tick();
    b_valid = 0;
    check("split_no_early_done", 64'(m_wdone), 0);
    tick();
    tick();
    check("split_w_hold2", 64'(w_valid), 1);
    w_ready = 1;
    tick();
    w_ready = 0;
    check("split_w_drop", 64'(w_valid), 0);
    b_valid = 1; b_id = 2;
    tick();
    check("split_foreign_b", 64'(m_wdone), 0);
    b_id = 0;
    tick();
    b_valid = 0;
    check("split_wdone", 64'(m_wdone), 64'b001);
    m_wreq = '0;
    tick();
    check("split_wdone_once", 64'(m_wdone), 0);
    check("split_stall_end", 64'(stall_o), 0);

    // Foreign read ID while dcache owns the read path
    m_rreq = 3'b010; m_raddr[1*AW +: AW] = 32'h0000_D000;
    tick();
    check("foreign_ar_id", 64'(ar_id), 1);
    ar_ready = 1;
    tick();
    ar_ready = 0;
    r_valid = 1; r_id = 0; r_data = 64'h55; r_last = 1;
    tick();
    check("foreign_no_rvalid", 64'(m_rvalid), 0);
    check("foreign_no_rdone", 64'(m_rdone), 0);
    r_id = 1; r_data = 64'h77;
    tick();
    r_valid = 0; r_last = 0;
    check("foreign_rvalid", 64'(m_rvalid), 64'b010);
    check("foreign_rdone", 64'(m_rdone), 64'b010);
    check("foreign_rdata", m_rdata, 64'h77);
    m_rreq = '0;
    tick();

    // Reset in the middle of a read burst for uncache
    m_rreq = 3'b100; m_raddr[2*AW +: AW] = 32'h0000_E000;
    tick();
    ar_ready = 1;
    tick();
    ar_ready = 0;
    r_valid = 1; r_id = 2; r_data = 64'h99; r_last = 0;
    tick();
    check("midrst_rvalid_before", 64'(m_rvalid), 64'b100);
    rst = 1'b0;
    #1;
    check("midrst_rvalid", 64'(m_rvalid), 0);
    check("midrst_rdata", m_rdata, 0);
    check("midrst_stall", 64'(stall_o), 0);
    check("midrst_ar_addr", 64'(ar_addr), 0);
    m_rreq = '0; r_valid = 0;
    tick();
    rst = 1'b1;
    tick();
    check("postrst_stall", 64'(stall_o), 0);
    check("postrst_ar_valid", 64'(ar_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
